// File: rtl/jacobi_pkg.sv
// Shared types and helpers for the Jacobi controller blocks.
package jacobi_pkg;

  typedef enum logic {
    SEND_FULL = 1'b0,
    SEND_DIAG = 1'b1
  } send_mode_e;

  typedef enum logic [1:0] {
    SND_IDLE,
    SND_STREAM,
    SND_DRAIN,
    SND_DONE
  } sender_state_e;

  // Adjacent diagonal elements of a row-major N x N matrix are N+1 words apart.
  function automatic int diag_stride(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/jacobi_out_fifo.sv
// Two-entry synchronous FIFO that decouples RAM read latency from the output handshake.
module jacobi_out_fifo #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop;

  assign do_pop = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + 2'(push) - 2'(do_pop);
    for (int i = 0; i < 2; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);
  assign count    = count_q;

endmodule

// File: rtl/jacobi_result_sender.sv
// Streams the result matrix (full or diagonal) from the shared RAM to the
// microcontroller over valid/ready, one word per cycle when ready is held high.
module jacobi_result_sender
  import jacobi_pkg::*;
#(
  parameter int N              = 8,
  parameter int OUT_WORD_WIDTH = 20,
  parameter int MEM_ADDR_WIDTH = 7,
  parameter int BASE_ADDR      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      mode_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      ram_en_o,
  output logic [MEM_ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [OUT_WORD_WIDTH-1:0] ram_dout_i,
  output logic [OUT_WORD_WIDTH-1:0] out_dat_o,
  output logic                      out_vld_o,
  input  logic                      out_rdy_i
);

  localparam int CNT_W = $clog2(N * N + 1);
  localparam logic [CNT_W-1:0]          TOTAL_FULL = CNT_W'(N * N);
  localparam logic [CNT_W-1:0]          TOTAL_DIAG = CNT_W'(N);
  localparam logic [MEM_ADDR_WIDTH-1:0] BASE       = MEM_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [MEM_ADDR_WIDTH-1:0] STEP_DIAG  = MEM_ADDR_WIDTH'(diag_stride(N));

  if (BASE_ADDR + N * N - 1 >= 2 ** MEM_ADDR_WIDTH) begin : g_addr_check
    $error("jacobi_result_sender: matrix does not fit in the RAM address space");
  end

  sender_state_e             state_q, state_d;
  send_mode_e                mode_q, mode_d;
  logic [CNT_W-1:0]          issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]          send_cnt_q, send_cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      inflight_q, inflight_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [CNT_W-1:0]          total;
  logic [MEM_ADDR_WIDTH-1:0] step;
  logic                      pop, slot_free, ram_en;
  logic                      fifo_full, fifo_empty;
  logic [1:0]                fifo_count;

  jacobi_out_fifo #(.W(OUT_WORD_WIDTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_dat (ram_dout_i),
    .pop      (pop),
    .head_dat (out_dat_o),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign out_vld_o = ~fifo_empty;
  assign pop       = out_vld_o & out_rdy_i;
  assign total     = (mode_q == SEND_DIAG) ? TOTAL_DIAG : TOTAL_FULL;
  assign step      = (mode_q == SEND_DIAG) ? STEP_DIAG : MEM_ADDR_WIDTH'(1);

  // Buffer plus in-flight read is committed at two words; a same-cycle pop
  // always frees room for the read that lands next cycle.
  assign slot_free = pop | ~(fifo_full | (inflight_q & (fifo_count == 2'd1)));
  assign ram_en    = (state_q == SND_STREAM) & slot_free;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    issue_cnt_d = issue_cnt_q;
    send_cnt_d  = send_cnt_q;
    addr_d      = addr_q;
    inflight_d  = ram_en;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    if (pop) begin
      send_cnt_d = send_cnt_q + CNT_W'(1);
    end
    if (ram_en) begin
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
      addr_d      = addr_q + step;
    end
    case (state_q)
      SND_IDLE: begin
        if (start_i) begin
          mode_d      = send_mode_e'(mode_i);
          issue_cnt_d = '0;
          send_cnt_d  = '0;
          addr_d      = BASE;
          state_d     = SND_STREAM;
          busy_d      = 1'b1;
        end
      end
      SND_STREAM: begin
        busy_d = 1'b1;
        if (ram_en && (issue_cnt_q == total - CNT_W'(1))) begin
          state_d = SND_DRAIN;
        end
      end
      SND_DRAIN: begin
        if (pop && (send_cnt_q == total - CNT_W'(1))) begin
          state_d = SND_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = SND_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SND_IDLE;
      mode_q      <= SEND_FULL;
      issue_cnt_q <= '0;
      send_cnt_q  <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      issue_cnt_q <= issue_cnt_d;
      send_cnt_q  <= send_cnt_d;
      addr_q      <= addr_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ram_en_o   = ram_en;
  assign ram_addr_o = addr_q;

endmodule
